// File: rtl/seg7_scan_ctrl.sv
// Multi-digit 7-segment sequencer: serial double-dabble binary-to-BCD conversion plus
// time-multiplexed digit scan with registered segment/anode outputs.
module seg7_scan_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_W-1:0]     value,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = $clog2(DIGITS);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [BCD_W-1:0]    adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_tmp_q, ovf_tmp_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic [SCAN_W-1:0]   scan_q, scan_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [3:0]          nib;
    logic                lead_zero;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovf_tmp_d = ovf_tmp_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        adj       = '0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shift_d   = value;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(DATA_W);
                    ovf_tmp_d = 1'b0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                for (int k = 0; k < int'(DIGITS); k++) begin
                    adj[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5) ?
                                    scratch_q[4*k +: 4] + 4'd3 : scratch_q[4*k +: 4];
                end
                scratch_d = {adj[BCD_W-2:0], shift_q[DATA_W-1]};
                shift_d   = shift_q << 1;
                // A bit leaving the top nibble means the value needs more digits than we have.
                ovf_tmp_d = ovf_tmp_q | adj[BCD_W-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = StCommit;
            end
            StCommit: begin
                bcd_d   = scratch_q;
                ovf_d   = ovf_tmp_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Outputs are registered from the current idx/bcd, so they trail either by one clock.
    always_comb begin
        nib       = 4'd0;
        lead_zero = 1'b1;
        an_d      = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            an_d[k] = (int'(idx_q) == k);
            if (int'(idx_q) == k) nib = bcd_q[4*k +: 4];
            if (k >= int'(idx_q) && bcd_q[4*k +: 4] != 4'd0) lead_zero = 1'b0;
        end
        seg_d = dec7(nib);
        if (ovf_q) begin
            seg_d = 7'b1000000;
        end else if (BLANK_LZ && idx_q != '0 && lead_zero) begin
            seg_d = 7'b0000000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_tmp_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            scan_q    <= '0;
            idx_q     <= '0;
            seg_q     <= 7'b0111111;
            an_q      <= DIGITS'(1);
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_tmp_q <= ovf_tmp_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign bcd      = bcd_q;
    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: three instances (3 digits blanked, 3 digits unblanked, 2 digits)
// share one stimulus stream and are checked every clock against a decimal-arithmetic model.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [7:0]  value = 8'd0;

    logic        busy_a, busy_b, busy_c;
    logic [11:0] bcd_a, bcd_b;
    logic [7:0]  bcd_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic [6:0]  seg_a, seg_b, seg_c;
    logic [2:0]  an_a, an_b;
    logic [1:0]  an_c;

    int tests = 0;
    int fails = 0;
    int t, cur_val, prev_val, pend_val, pend_c;
    bit pending;

    logic [6:0] seg_tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                 7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .busy(busy_a), .bcd(bcd_a),
        .overflow(ovf_a), .seg(seg_a), .an(an_a)
    );
    seg7_scan_ctrl #(.DATA_W(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .busy(busy_b), .bcd(bcd_b),
        .overflow(ovf_b), .seg(seg_b), .an(an_b)
    );
    seg7_scan_ctrl #(.DATA_W(8), .DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .busy(busy_c), .bcd(bcd_c),
        .overflow(ovf_c), .seg(seg_c), .an(an_c)
    );

    function automatic int pow10(int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(int v, int d);
        logic [11:0] r = '0;
        for (int k = 0; k < d; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] disp(int v, int idx, int d, bit blank);
        if (v >= pow10(d)) return 7'b1000000;
        if (blank && idx > 0 && v < pow10(idx)) return 7'b0000000;
        return seg_tbl[(v / pow10(idx)) % 10];
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic check_all();
        int  ip;
        bit  mb;
        ip = (t > 0) ? t - 1 : 0;
        mb = pending && (t >= pend_c + 1);
        check("busy_a", 16'(busy_a), 16'(mb));
        check("busy_b", 16'(busy_b), 16'(mb));
        check("busy_c", 16'(busy_c), 16'(mb));
        check("bcd_a", 16'(bcd_a), 16'(to_bcd(cur_val, 3)));
        check("bcd_b", 16'(bcd_b), 16'(to_bcd(cur_val, 3)));
        check("bcd_c", 16'(bcd_c), 16'(to_bcd(cur_val, 2)));
        check("ovf_a", 16'(ovf_a), 16'(cur_val >= 1000));
        check("ovf_b", 16'(ovf_b), 16'(cur_val >= 1000));
        check("ovf_c", 16'(ovf_c), 16'(cur_val >= 100));
        check("seg_a", 16'(seg_a), 16'(disp(prev_val, (ip / 4) % 3, 3, 1'b1)));
        check("seg_b", 16'(seg_b), 16'(disp(prev_val, (ip / 4) % 3, 3, 1'b0)));
        check("seg_c", 16'(seg_c), 16'(disp(prev_val, (ip / 4) % 2, 2, 1'b1)));
        check("an_a", 16'(an_a), 16'(1 << ((ip / 4) % 3)));
        check("an_b", 16'(an_b), 16'(1 << ((ip / 4) % 3)));
        check("an_c", 16'(an_c), 16'(1 << ((ip / 4) % 2)));
    endtask

    // Result of a load accepted in cycle c becomes visible in cycle c+10.
    task automatic step();
        @(posedge clk);
        #1;
        t++;
        prev_val = cur_val;
        if (pending && t == pend_c + 10) begin
            cur_val = pend_val;
            pending = 1'b0;
        end
        check_all();
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic do_load(int v);
        load  = 1'b1;
        value = 8'(v);
        if (!pending) begin
            pending  = 1'b1;
            pend_val = v;
            pend_c   = t;
        end
        step();
        load  = 1'b0;
        value = 8'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        t        = 0;
        cur_val  = 0;
        prev_val = 0;
        pending  = 1'b0;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();
        run(16);                        // idle scan rotation

        do_load(255);  run(14);
        do_load(7);    run(14);
        do_load(42);   step();          // second load lands while busy and is dropped
        do_load(99);   run(14);
        do_load(100);  run(14);
        do_load(99);   run(14);
        do_load(0);    run(14);
        do_load(10);   run(14);

        do_load(200);  run(3);
        do_reset();                     // mid-conversion reset
        run(2);
        do_load(13);   run(14);

        repeat (40) begin
            do_load(int'($urandom_range(0, 255)));
            run(int'($urandom_range(0, 12)));
        end
        run(14);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
